// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the asynchronous FIFO pointer blocks. Both the
//   write-side and the read-side pointer logic import this package.
//
//   Contents:
//     ADDR_W_DEF      default RAM address width
//     ALM_FULL_TH_DEF default almost-full threshold (free slots)
//     depth_of()      FIFO depth for a given address width
//     bin2gray()      binary -> reflected Gray code
//     gray2bin()      reflected Gray code -> binary
//     wflags_t        registered write-side flag pair
//
//   The code converters work on a full PTR_W_MAX-bit word. Callers
//   zero-extend narrower pointers into that word and slice the result back
//   down. Leading zeros do not change either conversion, so one function
//   pair serves every pointer width up to PTR_W_MAX.
package fifo_pkg;

    localparam int ADDR_W_DEF      = 4;
    localparam int ALM_FULL_TH_DEF = 2;
    localparam int PTR_W_MAX       = 32;

    typedef logic [PTR_W_MAX-1:0] ptr_word_t;

    typedef struct packed {
        logic full;
        logic alm_full;
    } wflags_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above its position.
    // A running XOR from the MSB down computes this.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = '0;
        b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
        for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-stage flop synchroniser for bringing a Gray-coded pointer across a
//   clock-domain boundary. An asynchronous active-low reset clears both
//   stages. The same module is instantiated on the read side for the
//   write pointer.
//
//   Ports:
//     clk    destination-domain clock
//     rst_n  asynchronous active-low reset
//     d      WIDTH-bit value from the foreign domain
//     q      WIDTH-bit value after two destination-domain flops
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // The first stage may go metastable. The second stage gives it a full
    // cycle to resolve. Because the input is Gray coded, any bit that
    // resolves either way still yields the old or the new pointer value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full
//   Write-domain pointer and flag generator for the asynchronous FIFO.
//   It keeps the binary write pointer and drives the RAM write address and
//   the Gray write pointer exported to the read domain. It also synchronises
//   the read pointer into clk_w and produces registered full, almost-full,
//   acknowledge and overflow indications.
//
//   Ports:
//     clk_w        write-domain clock (rising edge)
//     rst_w        asynchronous active-low reset
//     wr_en        write request
//     rd_ptr_gray  Gray read pointer from the read domain (asynchronous)
//     waddr        RAM write address (low bits of binary write pointer)
//     wr_ptr_gray  registered Gray write pointer, to the read domain
//     wr_ack       pulse: a write was accepted on the previous edge
//     full         registered full flag
//     alm_full     registered almost-full flag (free slots <= ALM_FULL_TH)
//     wr_overflow  pulse: wr_en was high while full was high
module fifo_wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int ALM_FULL_TH = ALM_FULL_TH_DEF
) (
    input  logic              clk_w,
    input  logic              rst_w,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   rd_ptr_gray,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W:0]   wr_ptr_gray,
    output logic              wr_ack,
    output logic              full,
    output logic              alm_full,
    output logic              wr_overflow
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = depth_of(ADDR_W);

    // Occupancy thresholds at pointer width, so the compares below need
    // no width conversion.
    localparam logic [ADDR_W:0] FULL_CNT = PTR_W'(DEPTH);
    localparam logic [ADDR_W:0] ALM_CNT  = PTR_W'(DEPTH - ALM_FULL_TH);

    logic [ADDR_W:0] wbin;
    logic [ADDR_W:0] wbin_next;
    logic [ADDR_W:0] wgray_next;
    logic [ADDR_W:0] rg_s;
    logic [ADDR_W:0] rbin_s;
    logic [ADDR_W:0] cnt_next;
    logic            wr_accept;
    wflags_t         flags_next;
    ptr_word_t       rbin_word;
    ptr_word_t       wgray_word;
    logic            unused_hi;

    sync_2ff #(
        .WIDTH (PTR_W)
    ) u_rptr_sync (
        .clk   (clk_w),
        .rst_n (rst_w),
        .d     (rd_ptr_gray),
        .q     (rg_s)
    );

    // Next-pointer and flag computation. The flags are computed from the
    // post-write pointer, so a write that fills the FIFO raises full on
    // that same edge. The synchronised read pointer lags the real one by
    // two edges. Occupancy can therefore only be over-estimated, so full
    // and alm_full may drop late but never drop early.
    always_comb begin
        rbin_word       = gray2bin(PTR_W_MAX'(rg_s));
        rbin_s          = rbin_word[ADDR_W:0];
        wr_accept       = wr_en && !full;
        wbin_next       = wbin + PTR_W'(wr_accept);
        wgray_word      = bin2gray(PTR_W_MAX'(wbin_next));
        wgray_next      = wgray_word[ADDR_W:0];
        cnt_next        = wbin_next - rbin_s;
        flags_next      = '0;
        flags_next.full     = (cnt_next == FULL_CNT);
        flags_next.alm_full = (cnt_next >= ALM_CNT);
    end

    // The upper bits of the package-width conversion words are always
    // zero here. This signal is declared only to sink them.
    assign unused_hi = ^{rbin_word[PTR_W_MAX-1:PTR_W], wgray_word[PTR_W_MAX-1:PTR_W]};

    // Pointer and flag registers. The flags are re-evaluated on every edge,
    // so a read-side free clears full without any write activity. On a
    // rejected write wbin_next equals wbin, so the pointers hold their value.
    always_ff @(posedge clk_w or negedge rst_w) begin
        if (!rst_w) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            wr_ack      <= 1'b0;
            full        <= 1'b0;
            alm_full    <= 1'b0;
            wr_overflow <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
            wr_ack      <= wr_accept;
            full        <= flags_next.full;
            alm_full    <= flags_next.alm_full;
            wr_overflow <= wr_en && full;
        end
    end

    assign waddr = wbin[ADDR_W-1:0];

endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full
//   Scoreboard bench for fifo_wptr_full with ADDR_W=4 and ALM_FULL_TH=2.
//   applyStimulus drives one cycle of inputs. It predicts the registered
//   outputs after the next rising edge from a small occupancy model and
//   pushes that prediction into a queue. A separate monitor pops one
//   prediction on each falling edge and compares it with the DUT.
//   Hand-derived constants are also checked at the key points of each
//   scenario.
module tb_fifo_wptr_full;

    localparam int ADDR_W      = 4;
    localparam int ALM_FULL_TH = 2;

    logic       clk_w = 1'b0;
    logic       rst_w;
    logic       wr_en;
    logic [4:0] rd_ptr_gray;
    logic [3:0] waddr;
    logic [4:0] wr_ptr_gray;
    logic       wr_ack;
    logic       full;
    logic       alm_full;
    logic       wr_overflow;

    typedef struct {
        logic [3:0] waddr;
        logic [4:0] gray;
        logic       ack;
        logic       full;
        logic       alm;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state. Read pointers are kept in binary; s1/s2 mimic the
    // two-edge synchroniser delay.
    logic [4:0] m_wbin;
    logic [4:0] m_s1;
    logic [4:0] m_s2;
    logic       m_full;

    fifo_wptr_full #(
        .ADDR_W      (ADDR_W),
        .ALM_FULL_TH (ALM_FULL_TH)
    ) dut (
        .clk_w       (clk_w),
        .rst_w       (rst_w),
        .wr_en       (wr_en),
        .rd_ptr_gray (rd_ptr_gray),
        .waddr       (waddr),
        .wr_ptr_gray (wr_ptr_gray),
        .wr_ack      (wr_ack),
        .full        (full),
        .alm_full    (alm_full),
        .wr_overflow (wr_overflow)
    );

    always #5 clk_w = ~clk_w;

    function automatic logic [4:0] toGray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_waddr"},    32'(waddr),       32'd0);
        checkOutput({tag, "_gray"},     32'(wr_ptr_gray), 32'd0);
        checkOutput({tag, "_ack"},      32'(wr_ack),      32'd0);
        checkOutput({tag, "_full"},     32'(full),        32'd0);
        checkOutput({tag, "_alm_full"}, 32'(alm_full),    32'd0);
        checkOutput({tag, "_overflow"}, 32'(wr_overflow), 32'd0);
    endtask

    task automatic modelReset();
        m_wbin = '0;
        m_s1   = '0;
        m_s2   = '0;
        m_full = 1'b0;
    endtask

    // Drives one cycle and predicts the outputs after the next rising edge.
    // Called at falling edge + 1; returns at the next falling edge + 1.
    task automatic applyStimulus(input logic we, input logic [4:0] rbin);
        exp_t       e;
        logic       acc;
        logic [4:0] nxt;
        logic [4:0] cnt;
        wr_en       = we;
        rd_ptr_gray = toGray(rbin);
        acc     = we && !m_full;
        nxt     = m_wbin + {4'b0000, acc};
        cnt     = nxt - m_s2;
        e.waddr = nxt[3:0];
        e.gray  = toGray(nxt);
        e.ack   = acc;
        e.ovf   = we && m_full;
        e.full  = (cnt == 5'd16);
        e.alm   = (cnt >= 5'd14);
        exp_q.push_back(e);
        m_full = e.full;
        m_wbin = nxt;
        m_s2   = m_s1;
        m_s1   = rbin;
        @(negedge clk_w);
        #1;
    endtask

    // Monitor: one prediction per clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_w);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("mon_waddr",    32'(waddr),       32'(e.waddr));
                checkOutput("mon_gray",     32'(wr_ptr_gray), 32'(e.gray));
                checkOutput("mon_ack",      32'(wr_ack),      32'(e.ack));
                checkOutput("mon_full",     32'(full),        32'(e.full));
                checkOutput("mon_alm_full", 32'(alm_full),    32'(e.alm));
                checkOutput("mon_overflow", 32'(wr_overflow), 32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got unfinished run, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] prev_gray;
        logic       wrapped;

        rst_w       = 1'b0;
        wr_en       = 1'b0;
        rd_ptr_gray = '0;
        modelReset();
        #2;
        checkResetState("reset_init");
        @(negedge clk_w);
        #1;
        rst_w = 1'b1;

        // First writes after release: address 0, then 1.
        checkOutput("waddr_at_release", 32'(waddr), 32'd0);
        applyStimulus(1'b1, 5'd0);
        checkOutput("waddr_after_first", 32'(waddr), 32'd1);
        applyStimulus(1'b1, 5'd0);
        applyStimulus(1'b1, 5'd0);

        // Mid-cycle reset with wr_en held high.
        rst_w = 1'b0;
        wr_en = 1'b1;
        #1;
        checkResetState("reset_mid");
        @(negedge clk_w);
        #1;
        checkResetState("reset_held");
        modelReset();
        rst_w = 1'b1;
        wr_en = 1'b0;

        // Fill with the read pointer parked at 0.
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 5'd0);
        checkOutput("alm_after_14", 32'(alm_full), 32'd1);
        checkOutput("full_after_14", 32'(full), 32'd0);
        applyStimulus(1'b1, 5'd0);
        checkOutput("full_after_15", 32'(full), 32'd0);
        applyStimulus(1'b1, 5'd0);
        checkOutput("full_after_16", 32'(full), 32'd1);
        checkOutput("gray_after_16", 32'(wr_ptr_gray), 32'h18);
        checkOutput("waddr_after_16", 32'(waddr), 32'd0);

        // Overflow: three rejected writes.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd0);
            checkOutput("ovf_pulse", 32'(wr_overflow), 32'd1);
            checkOutput("ovf_waddr_hold", 32'(waddr), 32'd0);
            checkOutput("ovf_gray_hold", 32'(wr_ptr_gray), 32'h18);
        end
        applyStimulus(1'b0, 5'd0);
        checkOutput("ovf_clear", 32'(wr_overflow), 32'd0);

        // Drain visibility: read pointer 0 -> 1 is seen after edge j+2.
        applyStimulus(1'b0, 5'd1);
        checkOutput("drain_full_j", 32'(full), 32'd1);
        applyStimulus(1'b0, 5'd1);
        checkOutput("drain_full_j1", 32'(full), 32'd1);
        applyStimulus(1'b0, 5'd1);
        checkOutput("drain_full_j2", 32'(full), 32'd0);
        checkOutput("drain_alm_j2", 32'(alm_full), 32'd1);

        // Write on the edge where the read increment is at sync stage 2.
        applyStimulus(1'b0, 5'd2);
        applyStimulus(1'b0, 5'd2);
        applyStimulus(1'b1, 5'd2);
        checkOutput("simul_full", 32'(full), 32'd0);
        checkOutput("simul_alm", 32'(alm_full), 32'd1);
        checkOutput("simul_ack", 32'(wr_ack), 32'd1);
        checkOutput("simul_waddr", 32'(waddr), 32'd1);

        // Wrap-around with the read pointer trailing by four.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, m_wbin - 5'd4);
        prev_gray = wr_ptr_gray;
        wrapped   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, m_wbin - 5'd4);
            checkOutput("wrap_one_bit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
            checkOutput("wrap_not_full", 32'(full), 32'd0);
            if (m_wbin == 5'd0) begin
                wrapped = 1'b1;
                checkOutput("wrap_gray_before", 32'(prev_gray), 32'h10);
                checkOutput("wrap_gray_after", 32'(wr_ptr_gray), 32'h00);
            end
            prev_gray = wr_ptr_gray;
        end
        checkOutput("wrap_seen", 32'(wrapped), 32'd1);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-side pointer and flag generator for the asynchronous FIFO, clocked in the write domain. It accepts write requests and produces the RAM write address and Gray-coded write pointer. It synchronises the read pointer into `clk_w` and generates registered `full`, `alm_full` and overflow indications. `alm_full` feeds the write-domain wrap-around delay register directly downstream; `wr_ptr_gray` goes to the read domain.

## Interface
Parameters:
- `ADDR_W`, default 4: RAM address width; depth `DEPTH = 2**ADDR_W`.
- `ALM_FULL_TH`, default 2: `alm_full` asserts when free slots <= `ALM_FULL_TH`; legal range 1..DEPTH-1.

Ports:
- `clk_w`  in  1  write-domain clock; one clock, all logic on rising edge.
- `rst_w`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write request; sampled on `clk_w`.
- `rd_ptr_gray`  in  ADDR_W+1  read pointer, Gray code, from read domain (asynchronous to `clk_w`).
- `waddr`  out  ADDR_W  RAM write address; low bits of binary write pointer.
- `wr_ptr_gray`  out  ADDR_W+1  registered Gray write pointer, to read domain.
- `wr_ack`  out  1  registered pulse: a write was accepted on the previous edge.
- `full`  out  1  registered full flag.
- `alm_full`  out  1  registered almost-full flag.
- `wr_overflow`  out  1  registered pulse: `wr_en` while `full` was high.

## Operation
- Write accepted iff `wr_en && !full`. Accepted write: RAM writes at the current `waddr`. Binary pointer `wbin` (ADDR_W+1 bits) then increments, mod 2**(ADDR_W+1).
- `rd_ptr_gray` passes through a 2-flop synchroniser, then gray-to-binary gives `rbin_s`.
- Occupancy: `cnt_next = (wbin_next - rbin_s) mod 2**(ADDR_W+1)`, range 0..DEPTH.
- `full <= (cnt_next == DEPTH)`. Equivalently, Gray compare: `wgray_next == {~rg_s[MSB:MSB-1], rg_s[MSB-2:0]}`.
- `alm_full <= (cnt_next >= DEPTH - ALM_FULL_TH)`; `full` implies `alm_full`.
- `wr_overflow <= wr_en && full`. Pointers, address and flags do not change on a rejected write.
- `wr_ptr_gray <= bin2gray(wbin_next)`; exactly one bit changes per accepted write.
- Wrap-around: `wbin` goes from 2**(ADDR_W+1)-1 to 0 with no special handling. For ADDR_W=4: 31→0, Gray 10000→00000. `waddr` goes from DEPTH-1 to 0 each lap.
- Flags are pessimistic:
  - Read-side frees are seen late, so `full` and `alm_full` may deassert late but never early.
  - No false "not full" is allowed.

## Timing
- Reset (`rst_w` low, asynchronous) forces:
  - `wbin`, `waddr`, `wr_ptr_gray` = 0;
  - both synchroniser stages = 0;
  - `wr_ack`, `full`, `alm_full`, `wr_overflow` = 0.
- Release is synchronous to the next `clk_w` edge.
- Write accepted at edge k:
  - `waddr`, `wr_ptr_gray` and `wr_ack` update at edge k.
  - `full` and `alm_full` reflecting that write are valid after edge k, the same edge. There is no extra flag latency on the write side.
- Read-pointer change stable before edge j: captured by sync flop 1 at j and flop 2 at j+1. Flags reflect it after edge j+2.
- Simultaneous write and read-pointer change: flags use the new `wbin_next` and the current `rbin_s`. The result is consistent, never under-reported.
- `wr_en` held high while full: `wr_overflow` stays high each cycle. Acceptance resumes on the first edge after `full` drops.
- Reset mid-operation: all state clears immediately. The read domain must be reset concurrently; no cross-domain reset handshake exists here.

## Structure
- Shared package `fifo_pkg`:
  - default `ADDR_W`;
  - `bin2gray` and `gray2bin` functions, parameterised by width;
  - `DEPTH` derivation.
- The read-side pointer block also uses `fifo_pkg`.
- Sub-module `sync_2ff` (parameter `WIDTH`): two-stage flop synchroniser with async active-low reset. It is reused for the read-domain copy of `wr_ptr_gray`.
- Expected size: about 150–200 lines of RTL, including `sync_2ff`.

## Test plan
All scenarios use ADDR_W=4 and ALM_FULL_TH=2.
- Reset: assert `rst_w` low mid-cycle with `wr_en`=1 → all outputs 0 immediately. First accepted write after release gives `waddr`=0 and then `waddr`=1.
- Fill with `rd_ptr_gray`=0:
  - 14 writes → `alm_full`=1 after the 14th edge, `full`=0;
  - 16th write → `full`=1;
  - `wr_ptr_gray`=5'b11000.
- Overflow: `wr_en`=1 for 3 cycles while full → `wr_overflow`=1 for 3 cycles; `waddr` stays 0 and `wr_ptr_gray` unchanged.
- Drain visibility: from full, `rd_ptr_gray` goes 0→5'b00001 before edge j → `full`=0 after edge j+2 and still 1 after j+1; `alm_full` stays 1.
- Wrap-around: 40 writes with `rd_ptr_gray` tracking wbin−4 →
  - `wbin` passes 31→0 and `wr_ptr_gray` 10000→00000;
  - one Gray bit toggles per write;
  - `full` never asserts.
- Simultaneous events: at count 15, `wr_en`=1 on the same edge a read-pointer increment arrives at sync stage 2 → count stays 15, `full`=0, `alm_full`=1.
